ram_stream_writer: RTL
======================

Name: ram_stream_writer

Overview:
- Write-side counterpart to the asynchronous single-port ROM blocks.
- Accepts a stream of data words over a valid/ready handshake and writes them into an internal 2**ADDR_WIDTH x DATA_WIDTH RAM at consecutive addresses from 0.
- Signals completion once every location has been written.
- Provides an asynchronous read port with the same addr->q behaviour as the ROMs, so the filled contents can be checked exactly as ROM contents are.

Parameters:
DATA_WIDTH, 8, width of each memory word and of the stream data
ADDR_WIDTH, 3, address width; depth = 2**ADDR_WIDTH words

Ports:
clk  input  1  system clock, all state changes on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  single-cycle request to begin (or restart) a fill at address 0
in_valid  input  1  stream word present on in_data
in_data  input  DATA_WIDTH  stream word
in_ready  output  1  block will accept in_data this cycle
rd_addr  input  ADDR_WIDTH  asynchronous read address
rd_data  output  DATA_WIDTH  mem[rd_addr], combinational
wr_count  output  ADDR_WIDTH+1  number of words written in current fill (0..2**ADDR_WIDTH)
busy  output  1  high in FILL state
done  output  1  high in DONE state

Behaviour:
- One clock, clk. Reset is asynchronous, active-low on rst_n.
- On rst_n low:
  - state=IDLE; wr_addr=0; wr_count=0; busy=0; done=0; in_ready=0.
  - Memory array is NOT cleared; contents are undefined until written.
- FSM states: IDLE, FILL, DONE.
  - IDLE: start=1 -> FILL, with wr_addr=0 and wr_count=0.
  - FILL: a beat is accepted when in_valid & in_ready at a rising edge.
    - On an accepted beat: mem[wr_addr]<=in_data; wr_addr<=wr_addr+1; wr_count<=wr_count+1.
    - The beat written at wr_addr=2**ADDR_WIDTH-1 moves the FSM to DONE on the same edge. wr_count becomes 2**ADDR_WIDTH and wr_addr wraps to 0.
    - in_valid low: hold state; no write.
  - DONE: in_ready=0. start=1 -> FILL, with wr_addr=0 and wr_count=0. Memory contents are retained until overwritten.
- in_ready = (state==FILL) & ~start, combinational.
  - start asserted in FILL restarts the fill: wr_addr=0, wr_count=0, stay in FILL.
  - The beat presented in that cycle is not accepted and no write occurs.
- busy = (state==FILL); done = (state==DONE). Both are registered-state decodes with no extra latency.
- Write latency: a word accepted at edge N is visible on rd_data from just after edge N, once rd_addr selects it.
- Same-address read during write: rd_data shows the old value before the edge and the new value after it.
- rd_data is purely combinational from rd_addr and the array, with no clock involvement and no reset dependency. The read port is usable in any state, including mid-fill.
- wr_count is ADDR_WIDTH+1 bits so a full fill (8 for defaults) is representable. It saturates by construction because no writes occur in DONE.
- Reset asserted mid-fill: FSM returns to IDLE immediately (asynchronous). Already-written words remain in memory and partial contents are left in place.
- in_data and in_valid are ignored outside FILL; no writes occur in IDLE or DONE.
- Single-port array: one write per cycle maximum. Read is independent.
- Target size: 120-250 lines RTL.

Test Plan:
- Reset and idle:
  - Stimulus: assert rst_n=0 for 2 cycles, release, hold start=0 for 5 cycles.
  - Required: busy=0, done=0, in_ready=0, wr_count=0 throughout. Words driven on in_data with in_valid=1 are not written.
- Full fill, back-to-back:
  - Stimulus: pulse start, then stream 8'b10101010, 11110000, 00001111, 11001100, 11100111, 00011000, 10110111, 11101101 with in_valid=1 every cycle.
  - Required: done=1 and wr_count=8 one edge after the 8th beat. Sweeping rd_addr 0..7 (10ps settle each) returns exactly that sequence.
- Stalled stream:
  - Stimulus: same data with in_valid low on alternate cycles.
  - Required: wr_count increments only on valid cycles. Final contents are identical to the back-to-back fill. done is asserted after exactly 8 accepted beats.
- Restart mid-fill:
  - Stimulus: write 3 words (0x11, 0x22, 0x33), then assert start while in_valid=1 with in_data=0x44, then stream 0xA0..0xA7.
  - Required: in_ready=0 in the start cycle and 0x44 is not written. wr_count goes to 0, then reaches 8. mem[0..7]=0xA0..0xA7.
- Reset mid-fill and refill:
  - Stimulus: fill with 0xA0..0xA7, restart with start, write 0x55 and 0x66, then pulse rst_n low asynchronously between edges.
  - Required: busy drops immediately and wr_count=0. mem[0]=0x55, mem[1]=0x66, mem[2..7]=0xA2..0xA7 remain readable.
- Read-during-write and DONE hold:
  - Stimulus: with rd_addr=3 during a fill, observe rd_data across the edge that writes address 3. After done, drive in_valid=1 with in_data=0xFF for 4 cycles.
  - Required: rd_data changes only after that edge. In DONE, in_ready stays 0 and contents are unchanged.

Source files
------------

// File: rtl/ram_stream_writer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : ram_stream_writer
// Brief    : Fills a 2**ADDR_WIDTH x DATA_WIDTH RAM from a valid/ready stream
//            at consecutive addresses from 0. Reports completion when every
//            location has been written. Exposes an asynchronous read port.
// Revision : 1.0  initial release
// ============================================================================
module ram_stream_writer #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [ADDR_WIDTH:0]   wr_count,
  output logic                  busy,
  output logic                  done
);

  localparam int                  DEPTH    = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = {ADDR_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                  state_q;
  logic [ADDR_WIDTH-1:0]   wr_addr_q;
  logic [ADDR_WIDTH-1:0]   wr_addr_d;
  logic [ADDR_WIDTH:0]     wr_count_q;
  logic [ADDR_WIDTH:0]     wr_count_d;
  logic                    accept;
  logic [DATA_WIDTH-1:0]   mem_q [0:DEPTH-1];

  // A start request takes priority over any beat presented in the same cycle,
  // so the stream is held off while the fill is (re)started.
  assign in_ready   = (state_q == ST_FILL) && !start;
  assign accept     = in_valid && in_ready;
  assign wr_addr_d  = wr_addr_q + 1'b1;
  assign wr_count_d = wr_count_q + 1'b1;

  assign busy     = (state_q == ST_FILL);
  assign done     = (state_q == ST_DONE);
  assign wr_count = wr_count_q;

  // Read port is a plain array lookup: no clock, no reset dependency.
  assign rd_data = mem_q[rd_addr];

  // Storage array: one write per accepted beat, never cleared by reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem_q[wr_addr_q] <= in_data;
    end
  end

  // Fill sequencer: tracks write address, word count and fill progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      wr_addr_q  <= '0;
      wr_count_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q    <= ST_FILL;
            wr_addr_q  <= '0;
            wr_count_q <= '0;
          end
        end
        ST_FILL: begin
          if (start) begin
            wr_addr_q  <= '0;
            wr_count_q <= '0;
          end else if (in_valid) begin
            // The last address wraps the pointer back to 0 and ends the fill.
            wr_addr_q  <= wr_addr_d;
            wr_count_q <= wr_count_d;
            if (wr_addr_q == ADDR_LAST) begin
              state_q <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          if (start) begin
            state_q    <= ST_FILL;
            wr_addr_q  <= '0;
            wr_count_q <= '0;
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          wr_addr_q  <= '0;
          wr_count_q <= '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
